load_store_unit: RTL and testbench

//  Memory-access stage consuming the datapath's ALU result (effective address) and rs2 (store data).

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/load_store_unit_align.sv | 53 +++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsu_state_e;

  typedef logic [3:0] be_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  // Unused funct3 encodings fall through to word.
  function automatic lsu_size_e size_of(
    input logic [2:0] f3
  );
    lsu_size_e sz;
    unique case (f3[1:0])
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    unique case (size_of(f3))
      SZ_H:    m = off[0];
      SZ_W:    m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for stores and lane extract/extend for loads.
// Purely combinational; word accesses ignore the address offset.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output be_t         be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ldata_o
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        sgn;

  always_comb begin
    be_o    = 4'hF;
    wdata_o = st_data_i;
    unique case (size_of(st_funct3_i))
      SZ_B: begin
        be_o    = be_t'(4'b0001 << st_off_i);
        wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'hF;
        wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    ld_b    = ld_data_i[{ld_off_i, 3'b000} +: 8];
    ld_h    = ld_off_i[1] ? ld_data_i[31:16]
                          : ld_data_i[15:0];
    sgn     = ~ld_funct3_i[2];
    ldata_o = ld_data_i;
    unique case (size_of(ld_funct3_i))
      SZ_B:    ldata_o = {{24{sgn & ld_b[7]}}, ld_b};
      SZ_H:    ldata_o = {{16{sgn & ld_h[15]}}, ld_h};
      default: ldata_o = ld_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage over a valid/ready + rvalid bus.
// LSU_MISALIGN_TRAP_EN adds a misalign output and skips bus traffic.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W =
    (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((RESP_TIMEOUT == 0) ? 0 : RESP_TIMEOUT - 1);
  localparam bit TO_EN = (RESP_TIMEOUT != 0);

  lsu_state_e       state_q;
  logic             bus_valid_q;
  logic             bus_we_q;
  logic [31:0]      bus_addr_q;
  be_t              bus_be_q;
  logic [31:0]      bus_wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       ld_f3_q;
  logic [1:0]       ld_off_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic             misalign_q;
`endif

  be_t         be_d;
  logic [31:0] wdata_d;
  logic [31:0] ldata_d;

  lsu_align u_align (
    .st_funct3_i (req_funct3),
    .st_off_i    (req_addr[1:0]),
    .st_data_i   (req_wdata),
    .be_o        (be_d),
    .wdata_o     (wdata_d),
    .ld_funct3_i (ld_f3_q),
    .ld_off_i    (ld_off_q),
    .ld_data_i   (bus_rdata),
    .ldata_o     (ldata_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ld_f3_q     <= '0;
      ld_off_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned(req_funct3, req_addr[1:0])) begin
              state_q    <= DONE;
              misalign_q <= 1'b1;
            end else
`endif
            begin
              state_q     <= REQ;
              bus_valid_q <= 1'b1;
              bus_we_q    <= req_we;
              bus_addr_q  <= {req_addr[31:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
              ld_f3_q     <= req_funct3;
              ld_off_q    <= req_addr[1:0];
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            cnt_q       <= '0;
            state_q     <= bus_we_q ? DONE : RESP;
          end
        end
        RESP: begin
          // Responses seen in any other state are stale and dropped.
          if (bus_rvalid) begin
            rdata_q <= ldata_d;
            state_q <= DONE;
          end else if (TO_EN && (cnt_q == CNT_LAST)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign stall     = req_valid & (state_q != DONE);
  assign done      = (state_q == DONE);
  assign rdata     = rdata_q;
  assign bus_err   = err_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Built with RESP_TIMEOUT=4; LSU_MISALIGN_TRAP_EN selects the trap test.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.RESP_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .bus_err    (bus_err),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign   (misalign),
`endif
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic set_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_bus: valid=%b we=%b be=%h want 0 0 0",
               bus_valid, bus_we, bus_be);
    end
    n_chk++;
    if (done !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ctl: done=%b stall=%b err=%b want 0 0 0",
               done, stall, bus_err);
    end
    n_chk++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata: got %h want 0", rdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    bus_ready = 1'b1;
    set_req(1'b1, F3_SW, 32'h100, 32'hDEADBEEF);
    #1;
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL sw_stall_idle: got %b want 1", stall);
    end
    @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL sw_req: valid=%b we=%b addr=%h want 1 1 00000100",
               bus_valid, bus_we, bus_addr);
    end
    n_chk++;
    if (bus_be !== 4'hF || bus_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_lanes: be=%h wdata=%h want f deadbeef",
               bus_be, bus_wdata);
    end
    n_chk++;
    if (stall !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_stall_req: stall=%b done=%b want 1 0", stall, done);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || stall !== 1'b0 || bus_valid !== 1'b0 ||
        bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_done: done=%b stall=%b valid=%b err=%b want 1 0 0 0",
               done, stall, bus_valid, bus_err);
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL sw_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    bus_ready = 1'b1;
    set_req(1'b1, F3_SH, 32'h102, 32'h0000BEEF);
    @(negedge clk);
    n_chk++;
    if (bus_be !== 4'b1100 || bus_wdata !== 32'hBEEFBEEF) begin
      n_fail++;
      $display("FAIL sh_lanes: be=%b wdata=%h want 1100 beefbeef",
               bus_be, bus_wdata);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL sh_done: done=%b want 1", done);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || bus_valid !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: done=%b valid=%b stall=%b want 0 0 1",
               done, bus_valid, stall);
    end
    set_req(1'b1, F3_SB, 32'h103, 32'h123456A5);
    @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b1 || bus_be !== 4'b1000 ||
        bus_wdata !== 32'hA5A5A5A5 || bus_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL sb_req: valid=%b be=%b wdata=%h addr=%h want 1 1000 a5a5a5a5 00000100",
               bus_valid, bus_be, bus_wdata, bus_addr);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL sb_done: done=%b want 1", done);
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte(input logic [2:0] f3,
                                input logic [31:0] exp,
                                input string nm);
    bus_ready = 1'b1;
    set_req(1'b0, f3, 32'h102, 32'h0);
    @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b1 || bus_we !== 1'b0 || bus_be !== 4'b0100 ||
        bus_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL %s_req: valid=%b we=%b be=%b addr=%h want 1 0 0100 00000100",
               nm, bus_valid, bus_we, bus_be, bus_addr);
    end
    @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_resp: valid=%b stall=%b done=%b want 0 1 0",
               nm, bus_valid, stall, done);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'h00800000;
    @(negedge clk);
    bus_rvalid = 1'b0;
    n_chk++;
    if (done !== 1'b1 || rdata !== exp || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_data: done=%b rdata=%h err=%b want 1 %h 0",
               nm, done, rdata, bus_err, exp);
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ready_stall();
    bus_ready = 1'b0;
    set_req(1'b0, F3_LH, 32'h102, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus_valid !== 1'b1 || bus_addr !== 32'h100 ||
          bus_be !== 4'b1100 || stall !== 1'b1) begin
        n_fail++;
        $display("FAIL lh_hold%0d: valid=%b addr=%h be=%b stall=%b want 1 00000100 1100 1",
                 i, bus_valid, bus_addr, bus_be, stall);
      end
    end
    bus_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL lh_hs: valid=%b done=%b want 0 0", bus_valid, done);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'hBEEF1234;
    @(negedge clk);
    bus_rvalid = 1'b0;
    n_chk++;
    if (done !== 1'b1 || rdata !== 32'hFFFFBEEF) begin
      n_fail++;
      $display("FAIL lh_data: done=%b rdata=%h want 1 ffffbeef", done, rdata);
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_rvalid();
    bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    set_req(1'b0, F3_LHU, 32'h100, 32'h0);
    repeat (2) @(negedge clk);
    bus_rvalid = 1'b0; bus_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lhu_stray: done=%b stall=%b want 0 1", done, stall);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'hBEEF8765;
    @(negedge clk);
    bus_rvalid = 1'b0;
    n_chk++;
    if (done !== 1'b1 || rdata !== 32'h00008765) begin
      n_fail++;
      $display("FAIL lhu_data: done=%b rdata=%h want 1 00008765", done, rdata);
    end
    set_req(1'b0, F3_LW, 32'h104, 32'h0);
    @(negedge clk);
    set_req(1'b0, F3_LW, 32'h104, 32'h0);
    repeat (2) @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'h13579BDF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    n_chk++;
    if (done !== 1'b1 || rdata !== 32'h13579BDF) begin
      n_fail++;
      $display("FAIL lw_data: done=%b rdata=%h want 1 13579bdf", done, rdata);
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bus_ready = 1'b1; bus_rvalid = 1'b0;
    set_req(1'b0, F3_LW, 32'h200, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL to_wait%0d: done=%b want 0", i, done);
      end
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || bus_err !== 1'b1 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL to_done: done=%b err=%b rdata=%h want 1 1 0",
               done, bus_err, rdata);
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus_ready = 1'b0;
    set_req(1'b1, F3_SW, 32'h300, 32'h55AA55AA);
    @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL rm_req: valid=%b want 1", bus_valid);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_drop: valid=%b done=%b want 0 0", bus_valid, done);
    end
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; bus_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_noretry: valid=%b done=%b want 0 0", bus_valid, done);
    end
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic test_misalign();
    bus_ready = 1'b1;
    set_req(1'b0, F3_LW, 32'h101, 32'h0);
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || misalign !== 1'b1 || bus_valid !== 1'b0 ||
        rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_lw: done=%b mis=%b valid=%b rdata=%h want 1 1 0 0",
               done, misalign, bus_valid, rdata);
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (misalign !== 1'b0 || bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_clr: mis=%b valid=%b want 0 0", misalign, bus_valid);
    end
  endtask
`else
  task automatic test_half_odd();
    bus_ready = 1'b1;
    set_req(1'b1, F3_SH, 32'h103, 32'hCAFE1234);
    @(negedge clk);
    n_chk++;
    if (bus_valid !== 1'b1 || bus_be !== 4'b1100 ||
        bus_wdata !== 32'h12341234) begin
      n_fail++;
      $display("FAIL sh_odd: valid=%b be=%b wdata=%h want 1 1100 12341234",
               bus_valid, bus_be, bus_wdata);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_store_word();
    test_back_to_back();
    test_load_byte(F3_LB, 32'hFFFFFF80, "lb");
    test_load_byte(F3_LBU, 32'h00000080, "lbu");
    test_ready_stall();
    test_stray_rvalid();
    test_timeout();
    test_reset_mid();
`ifdef LSU_MISALIGN_TRAP_EN
    test_misalign();
`else
    test_half_odd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
